// File: rtl/mem_access_responder_if.sv
// Request/response bundle between a memory-access master and mem_access_responder.
interface mem_access_responder_if #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned SERIAL_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0]   memAccessAddr;
  logic [DATA_WIDTH-1:0]   memAccessWriteData;
  logic                    memAccessRE;
  logic                    memAccessWE;
  logic                    memAccessReadBusy;
  logic                    memAccessWriteBusy;
  logic [SERIAL_WIDTH-1:0] nextMemReadSerial;
  logic [SERIAL_WIDTH-1:0] nextMemWriteSerial;
  logic                    memReadDataReady;
  logic [DATA_WIDTH-1:0]   memReadData;
  logic [SERIAL_WIDTH-1:0] memReadSerial;
  logic                    memAccessResponseValid;
  logic [SERIAL_WIDTH-1:0] memAccessResponseSerial;

  modport master (
    output memAccessAddr, memAccessWriteData, memAccessRE, memAccessWE,
    input  memAccessReadBusy, memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial,
    input  memReadDataReady, memReadData, memReadSerial,
    input  memAccessResponseValid, memAccessResponseSerial
  );

  modport slave (
    input  memAccessAddr, memAccessWriteData, memAccessRE, memAccessWE,
    output memAccessReadBusy, memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial,
    output memReadDataReady, memReadData, memReadSerial,
    output memAccessResponseValid, memAccessResponseSerial
  );
endinterface

// File: rtl/mem_access_responder.sv
// Fixed-latency memory model: internal array with serial-tagged read returns and
// write completions delivered through shift pipelines, bounded outstanding requests.
module mem_access_responder #(
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned SERIAL_WIDTH       = 4,
  parameter int unsigned DEPTH_WORDS        = 1024,
  parameter int unsigned READ_LATENCY       = 4,
  parameter int unsigned WRITE_LATENCY      = 2,
  parameter int unsigned MAX_READ_INFLIGHT  = 3,
  parameter int unsigned MAX_WRITE_INFLIGHT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_responder_if.slave bus
);
  localparam int unsigned OFFS_W = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned RCNT_W = $clog2(MAX_READ_INFLIGHT + 1);
  localparam int unsigned WCNT_W = $clog2(MAX_WRITE_INFLIGHT + 1);
  localparam logic [RCNT_W-1:0] RMAX = RCNT_W'(MAX_READ_INFLIGHT);
  localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(MAX_WRITE_INFLIGHT);

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH_WORDS];
  logic [IDX_W-1:0]        w_idx;
  logic                    w_unused_addr;
  logic                    w_rd_acc, w_wr_acc, w_rd_ret, w_wr_ret;
  logic [RCNT_W-1:0]       r_rd_cnt;
  logic [WCNT_W-1:0]       r_wr_cnt;
  logic [SERIAL_WIDTH-1:0] r_rd_serial, r_wr_serial;
  logic [READ_LATENCY-1:0] r_rd_vld;
  logic [SERIAL_WIDTH-1:0] r_rd_ser [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   r_rd_dat [READ_LATENCY];
  logic [WRITE_LATENCY-1:0] r_wr_vld;
  logic [SERIAL_WIDTH-1:0] r_wr_ser [WRITE_LATENCY];

  // Upper and sub-entry address bits are ignored, so distant addresses alias.
  assign w_idx = bus.memAccessAddr[OFFS_W +: IDX_W];
  assign w_unused_addr = ^{bus.memAccessAddr[ADDR_WIDTH-1:OFFS_W+IDX_W],
                           bus.memAccessAddr[OFFS_W-1:0]};

  assign bus.memAccessReadBusy  = (r_rd_cnt == RMAX);
  assign bus.memAccessWriteBusy = (r_wr_cnt == WMAX);
  assign w_rd_acc = bus.memAccessRE && !bus.memAccessReadBusy;
  assign w_wr_acc = bus.memAccessWE && !bus.memAccessWriteBusy;
  assign w_rd_ret = r_rd_vld[READ_LATENCY-1];
  assign w_wr_ret = r_wr_vld[WRITE_LATENCY-1];

  // Array is deliberately not reset; the read pipeline captures pre-write contents.
  always_ff @(posedge clk) begin
    if (rst && w_wr_acc) r_mem[w_idx] <= bus.memAccessWriteData;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_vld    <= '0;
      r_rd_cnt    <= '0;
      r_rd_serial <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        r_rd_ser[i] <= '0;
        r_rd_dat[i] <= '0;
      end
    end else begin
      r_rd_vld[0] <= w_rd_acc;
      r_rd_ser[0] <= w_rd_acc ? r_rd_serial : '0;
      r_rd_dat[0] <= w_rd_acc ? r_mem[w_idx] : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_ser[i] <= r_rd_ser[i-1];
        r_rd_dat[i] <= r_rd_dat[i-1];
      end
      if (w_rd_acc) r_rd_serial <= r_rd_serial + 1'b1;
      case ({w_rd_acc, w_rd_ret})
        2'b10:   r_rd_cnt <= r_rd_cnt + 1'b1;
        2'b01:   r_rd_cnt <= r_rd_cnt - 1'b1;
        default: r_rd_cnt <= r_rd_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_vld    <= '0;
      r_wr_cnt    <= '0;
      r_wr_serial <= '0;
      for (int unsigned i = 0; i < WRITE_LATENCY; i++) r_wr_ser[i] <= '0;
    end else begin
      r_wr_vld[0] <= w_wr_acc;
      r_wr_ser[0] <= w_wr_acc ? r_wr_serial : '0;
      for (int unsigned i = 1; i < WRITE_LATENCY; i++) begin
        r_wr_vld[i] <= r_wr_vld[i-1];
        r_wr_ser[i] <= r_wr_ser[i-1];
      end
      if (w_wr_acc) r_wr_serial <= r_wr_serial + 1'b1;
      case ({w_wr_acc, w_wr_ret})
        2'b10:   r_wr_cnt <= r_wr_cnt + 1'b1;
        2'b01:   r_wr_cnt <= r_wr_cnt - 1'b1;
        default: r_wr_cnt <= r_wr_cnt;
      endcase
    end
  end

  assign bus.nextMemReadSerial       = r_rd_serial;
  assign bus.nextMemWriteSerial      = r_wr_serial;
  assign bus.memReadDataReady        = w_rd_ret;
  assign bus.memReadData             = r_rd_dat[READ_LATENCY-1];
  assign bus.memReadSerial           = r_rd_ser[READ_LATENCY-1];
  assign bus.memAccessResponseValid  = w_wr_ret;
  assign bus.memAccessResponseSerial = r_wr_ser[WRITE_LATENCY-1];
endmodule

// File: tb/tb_mem_access_responder.sv
// Directed bench for mem_access_responder at default parameters.
module tb_mem_access_responder;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 4;
  localparam logic [63:0] D40 = 64'h1122334455667788;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  mem_access_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SERIAL_WIDTH(SW)) bus ();

  mem_access_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SERIAL_WIDTH(SW), .DEPTH_WORDS(1024),
    .READ_LATENCY(4), .WRITE_LATENCY(2), .MAX_READ_INFLIGHT(3), .MAX_WRITE_INFLIGHT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    logic [17:0] busy_m, ret_m;
    logic [15:0] ser4;
    logic [8:0]  wbusy_m;
    int unsigned nret, pulses;
    int unsigned acc, rsp, maxo, ser_err, lat_err, cyc;
    int unsigned acc_cyc[$];

    rst = 1'b0;
    bus.memAccessRE = 1'b0;
    bus.memAccessWE = 1'b0;
    bus.memAccessAddr = '0;
    bus.memAccessWriteData = '0;
    repeat (3) step();
    check("rst_rbusy", bus.memAccessReadBusy, 0);
    check("rst_wbusy", bus.memAccessWriteBusy, 0);
    check("rst_rser", bus.nextMemReadSerial, 0);
    check("rst_wser", bus.nextMemWriteSerial, 0);
    check("rst_rdy", bus.memReadDataReady, 0);
    check("rst_rsp", bus.memAccessResponseValid, 0);
    rst = 1'b1;

    // write 0x40 at cycle 0, read 0x40 at cycle 1
    bus.memAccessWE = 1'b1;
    bus.memAccessAddr = 32'h40;
    bus.memAccessWriteData = D40;
    step();
    bus.memAccessWE = 1'b0;
    bus.memAccessRE = 1'b1;
    check("c1_rser", bus.nextMemReadSerial, 0);
    check("c1_wser", bus.nextMemWriteSerial, 1);
    step();
    bus.memAccessRE = 1'b0;
    check("c2_rspv", bus.memAccessResponseValid, 1);
    check("c2_rsps", bus.memAccessResponseSerial, 0);
    check("c2_rser", bus.nextMemReadSerial, 1);
    step();
    check("c3_rspv", bus.memAccessResponseValid, 0);
    check("c3_rdy", bus.memReadDataReady, 0);
    step();
    check("c4_rdy", bus.memReadDataReady, 0);
    step();
    check("c5_rdy", bus.memReadDataReady, 1);
    check("c5_data", bus.memReadData, D40);
    check("c5_ser", bus.memReadSerial, 0);
    step();
    check("c6_rdy", bus.memReadDataReady, 0);
    check("c6_data", bus.memReadData, 0);
    check("c6_ser", bus.memReadSerial, 0);

    // same-cycle read/write to 0x80
    bus.memAccessWE = 1'b1;
    bus.memAccessAddr = 32'h80;
    bus.memAccessWriteData = 64'hAA;
    step();
    bus.memAccessRE = 1'b1;
    bus.memAccessWriteData = 64'hBB;
    step();
    bus.memAccessWE = 1'b0;
    step();
    bus.memAccessRE = 1'b0;
    step();
    step();
    check("rw_old_rdy", bus.memReadDataReady, 1);
    check("rw_old_data", bus.memReadData, 64'hAA);
    check("rw_old_ser", bus.memReadSerial, 1);
    step();
    check("rw_new_rdy", bus.memReadDataReady, 1);
    check("rw_new_data", bus.memReadData, 64'hBB);
    check("rw_new_ser", bus.memReadSerial, 2);
    step();
    check("rw_idle", bus.memReadDataReady, 0);

    // alias 0x2040 -> entry of 0x40
    bus.memAccessRE = 1'b1;
    bus.memAccessAddr = 32'h2040;
    step();
    bus.memAccessRE = 1'b0;
    step();
    step();
    step();
    check("alias_rdy", bus.memReadDataReady, 1);
    check("alias_data", bus.memReadData, D40);
    check("alias_ser", bus.memReadSerial, 3);

    // reset with two reads in flight
    bus.memAccessRE = 1'b1;
    bus.memAccessAddr = 32'h40;
    step();
    step();
    bus.memAccessRE = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_rbusy", bus.memAccessReadBusy, 0);
    check("mid_rst_rser", bus.nextMemReadSerial, 0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.memReadDataReady) pulses++;
      step();
    end
    check("mid_rst_pulses", pulses, 0);

    // RE held high for 10 cycles
    busy_m = '0;
    ret_m = '0;
    ser4 = '0;
    nret = 0;
    for (int c = 0; c < 18; c++) begin
      bus.memAccessRE = (c < 10);
      busy_m[c] = bus.memAccessReadBusy;
      if (bus.memReadDataReady) begin
        ret_m[c] = 1'b1;
        if (nret < 4) ser4 = {ser4[11:0], bus.memReadSerial};
        if (nret == 0) check("burst_data0", bus.memReadData, D40);
        nret++;
      end
      step();
    end
    check("burst_busy", busy_m[9:0], 10'h318);
    check("burst_ret", ret_m, 18'h00E70);
    check("burst_ser", ser4, 16'h0123);
    check("burst_nret", nret, 6);

    // 20 accepted writes
    acc = 0; rsp = 0; maxo = 0; ser_err = 0; lat_err = 0; cyc = 0;
    wbusy_m = '0;
    while (cyc < 100 && (acc < 20 || rsp < 20)) begin
      bus.memAccessWE = (acc < 20);
      bus.memAccessAddr = 32'h100 + acc * 8;
      bus.memAccessWriteData = 64'(acc);
      if (cyc < 9) wbusy_m[cyc] = bus.memAccessWriteBusy;
      if (acc - rsp > maxo) maxo = acc - rsp;
      if (bus.memAccessResponseValid) begin
        if (bus.memAccessResponseSerial !== 4'(rsp % 16)) ser_err++;
        if (acc_cyc.size() == 0 || cyc - acc_cyc.pop_front() != 2) lat_err++;
        rsp++;
      end
      if (bus.memAccessWE && !bus.memAccessWriteBusy) begin
        acc_cyc.push_back(cyc);
        acc++;
      end
      step();
      cyc++;
    end
    bus.memAccessWE = 1'b0;
    check("wr_acc", acc, 20);
    check("wr_rsp", rsp, 20);
    check("wr_maxo", maxo, 2);
    check("wr_ser_err", ser_err, 0);
    check("wr_lat_err", lat_err, 0);
    check("wr_busy", wbusy_m, 9'h124);
    check("wr_next_ser", bus.nextMemWriteSerial, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
